// File: rtl/ex_div_if.sv
// Operand/result bundle between the execute stage (master) and the divider (slave).
// Signal names match the divider's port list so both sides read the same.
interface ex_div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, busy_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, busy_o
   );
endinterface

// File: rtl/ex_div.sv
// 32-iteration restoring divider for MIPS DIV/DIVU.
// Produces {HI=remainder, LO=quotient} with MIPS sign rules; divide-by-zero yields 0.
module ex_div (
   input  logic     clk,
   input  logic     rst,
   ex_div_if.slave  bus
);
   typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [64:0] work_q;
   logic [31:0] divisor_q;
   logic        signed_q;
   logic        neg1_q;
   logic        neg2_q;
   logic [63:0] result_q;
   logic        ready_q;
   logic        busy_q;

   logic [31:0] mag1_d;
   logic [31:0] mag2_d;
   logic [32:0] trial_d;
   logic [31:0] quot_d;
   logic [31:0] rem_d;

   // Magnitudes are only taken for DIV; DIVU passes operands through untouched.
   assign mag1_d  = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1)
                                                             : bus.opdata1_i;
   assign mag2_d  = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1)
                                                             : bus.opdata2_i;
   assign trial_d = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
   assign quot_d  = (signed_q && (neg1_q ^ neg2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
   assign rem_d   = (signed_q && neg1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FREE;
         cnt_q     <= 6'd0;
         work_q    <= '0;
         divisor_q <= '0;
         signed_q  <= 1'b0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_FREE: begin
               if (bus.start_i && !bus.annul_i) begin
                  signed_q <= bus.signed_div_i;
                  neg1_q   <= bus.opdata1_i[31];
                  neg2_q   <= bus.opdata2_i[31];
                  busy_q   <= 1'b1;
                  if (bus.opdata2_i == 32'd0) begin
                     state_q <= S_BY_ZERO;
                  end else begin
                     work_q    <= {32'd0, mag1_d, 1'b0};
                     divisor_q <= mag2_d;
                     cnt_q     <= 6'd0;
                     state_q   <= S_ON;
                  end
               end
            end
            S_BY_ZERO: begin
               result_q <= '0;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_END;
            end
            S_ON: begin
               if (bus.annul_i) begin
                  busy_q  <= 1'b0;
                  state_q <= S_FREE;
               end else if (cnt_q != 6'd32) begin
                  // Keep the shifted remainder when the trial subtraction borrows.
                  if (trial_d[32]) work_q <= work_q << 1;
                  else             work_q <= {trial_d[31:0], work_q[31:0], 1'b1};
                  cnt_q <= cnt_q + 6'd1;
               end else begin
                  result_q <= {rem_d, quot_d};
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_END;
               end
            end
            S_END: begin
               if (!bus.start_i || bus.annul_i) begin
                  result_q <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= S_FREE;
               end
            end
            default: state_q <= S_FREE;
         endcase
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;
   assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, sign handling, divide-by-zero, annul, reset and hold.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ex_div;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ex_div_if dif ();

   ex_div dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present an operation; the next rising edge accepts it.
   task automatic drive(input logic sd, input logic [31:0] a, input logic [31:0] b);
      dif.signed_div_i = sd;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      dif.start_i      = 1'b1;
      dif.annul_i      = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      checks++;
      if (dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %0b want 0", dif.ready_o);
      end
      checks++;
      if (dif.result_o !== 64'd0) begin
         errors++; $display("FAIL reset_result got %h want 0", dif.result_o);
      end
      checks++;
      if (dif.busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %0b want 0", dif.busy_o);
      end
      rst = 1'b0;
      tick(1);
      $display("reset: ready=%0b busy=%0b result=%h", dif.ready_o, dif.busy_o, dif.result_o);
   endtask

   task automatic test_divu;
      drive(1'b0, 32'd100, 32'd7);
      tick(1);
      checks++;
      if (dif.busy_o !== 1'b1) begin
         errors++; $display("FAIL divu_busy got %0b want 1", dif.busy_o);
      end
      tick(32);
      checks++;
      if (dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL divu_early_ready got %0b want 0", dif.ready_o);
      end
      tick(1);
      checks++;
      if (dif.ready_o !== 1'b1) begin
         errors++; $display("FAIL divu_ready got %0b want 1", dif.ready_o);
      end
      checks++;
      if (dif.result_o !== {32'd2, 32'd14}) begin
         errors++; $display("FAIL divu_result got %h want %h", dif.result_o, {32'd2, 32'd14});
      end
      checks++;
      if (dif.busy_o !== 1'b0) begin
         errors++; $display("FAIL divu_busy_end got %0b want 0", dif.busy_o);
      end
      dif.start_i = 1'b0;
      tick(1);
      checks++;
      if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
         errors++; $display("FAIL divu_drop got ready=%0b result=%h want 0/0", dif.ready_o, dif.result_o);
      end
      $display("divu 100/7: result=%h", {32'd2, 32'd14});
   endtask

   task automatic test_signed;
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [63:0] vr [3];
      va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vr[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
      va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; vr[1] = {32'd1, 32'hFFFFFFFD};
      va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vr[2] = {32'd0, 32'h80000000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, va[i], vb[i]);
         tick(34);
         checks++;
         if (dif.ready_o !== 1'b1 || dif.result_o !== vr[i]) begin
            errors++;
            $display("FAIL signed_%0d got ready=%0b result=%h want 1/%h", i, dif.ready_o, dif.result_o, vr[i]);
         end
         $display("div %h/%h: result=%h", va[i], vb[i], dif.result_o);
         dif.start_i = 1'b0;
         tick(1);
      end
   endtask

   task automatic test_div_zero;
      drive(1'b1, 32'd5, 32'd0);
      tick(1);
      checks++;
      if (dif.busy_o !== 1'b1 || dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL divzero_c1 got busy=%0b ready=%0b want 1/0", dif.busy_o, dif.ready_o);
      end
      tick(1);
      checks++;
      if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b1) begin
         errors++; $display("FAIL divzero_c2 got busy=%0b ready=%0b want 0/1", dif.busy_o, dif.ready_o);
      end
      checks++;
      if (dif.result_o !== 64'd0) begin
         errors++; $display("FAIL divzero_result got %h want 0", dif.result_o);
      end
      dif.start_i = 1'b0;
      tick(1);
      $display("div 5/0: result=%h", dif.result_o);
   endtask

   task automatic test_annul;
      bit seen;
      // Annul together with start in FREE must not be accepted.
      drive(1'b0, 32'd9, 32'd3);
      dif.annul_i = 1'b1;
      tick(3);
      checks++;
      if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL annul_free got busy=%0b ready=%0b want 0/0", dif.busy_o, dif.ready_o);
      end
      drive(1'b0, 32'd1000, 32'd3);
      tick(11);
      dif.annul_i = 1'b1;
      dif.start_i = 1'b0;
      tick(1);
      checks++;
      if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL annul_on got busy=%0b ready=%0b want 0/0", dif.busy_o, dif.ready_o);
      end
      dif.annul_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (dif.ready_o === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL annul_no_ready got %0b want 0", seen);
      end
      drive(1'b0, 32'hFFFFFFFF, 32'd1);
      tick(33);
      checks++;
      if (dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL after_annul_early got %0b want 0", dif.ready_o);
      end
      tick(1);
      checks++;
      if (dif.ready_o !== 1'b1 || dif.result_o !== {32'd0, 32'hFFFFFFFF}) begin
         errors++; $display("FAIL after_annul got ready=%0b result=%h want 1/%h", dif.ready_o, dif.result_o, {32'd0, 32'hFFFFFFFF});
      end
      // Annul in END wins over a still-high start.
      dif.annul_i = 1'b1;
      tick(1);
      checks++;
      if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
         errors++; $display("FAIL annul_end got ready=%0b result=%h want 0/0", dif.ready_o, dif.result_o);
      end
      dif.annul_i = 1'b0;
      dif.start_i = 1'b0;
      tick(1);
      $display("annul: done");
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 32'd500, 32'd5);
      tick(21);
      rst = 1'b1;
      dif.start_i = 1'b0;
      tick(1);
      checks++;
      if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
         errors++; $display("FAIL reset_mid got busy=%0b ready=%0b result=%h want 0/0/0", dif.busy_o, dif.ready_o, dif.result_o);
      end
      rst = 1'b0;
      tick(40);
      checks++;
      if (dif.ready_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_idle got %0b want 0", dif.ready_o);
      end
      $display("reset mid-ON: outputs cleared");
   endtask

   task automatic test_hold;
      drive(1'b0, 32'd100, 32'd7);
      tick(5);
      dif.opdata1_i    = 32'd0;
      dif.opdata2_i    = 32'd0;
      dif.signed_div_i = 1'b1;
      tick(29);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dif.ready_o !== 1'b1 || dif.result_o !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL hold_%0d got ready=%0b result=%h want 1/%h", i, dif.ready_o, dif.result_o, {32'd2, 32'd14});
         end
         tick(1);
      end
      $display("hold: result=%h", dif.result_o);
   endtask

   task automatic test_back_to_back;
      dif.start_i = 1'b0;
      tick(1);
      drive(1'b0, 32'd1000, 32'd10);
      tick(34);
      checks++;
      if (dif.ready_o !== 1'b1 || dif.result_o !== {32'd0, 32'd100}) begin
         errors++; $display("FAIL back_to_back got ready=%0b result=%h want 1/%h", dif.ready_o, dif.result_o, {32'd0, 32'd100});
      end
      dif.start_i = 1'b0;
      tick(1);
      $display("back-to-back divu 1000/10: result=%h", {32'd0, 32'd100});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd0;
      dif.opdata2_i    = 32'd0;
      dif.start_i      = 1'b0;
      dif.annul_i      = 1'b0;
      tick(1);
      test_reset;
      test_divu;
      test_signed;
      test_div_zero;
      test_annul;
      test_reset_mid;
      test_hold;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
